// File: rtl/pe_array_pkg.sv
// Shared types and the round/saturate helper for the outer-product PE array.
package pe_array_pkg;

    localparam int DW_DEF    = 16;
    localparam int ACC_W_DEF = 40;
    // Working width for rounding; must cover the widest accumulator in use.
    localparam int RS_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        HOLD
    } state_t;

    typedef struct packed {
        logic            sat;
        logic [RS_W-1:0] value;
    } rs_t;

    // acc arrives sign-extended to RS_W. Shifts past the accumulator width
    // give pure sign fill, so the rounding bit is suppressed there.
    function automatic rs_t round_sat(
        input logic signed [RS_W-1:0] acc,
        input logic        [5:0]      shift,
        input logic                   round_en,
        input int                     acc_w,
        input int                     dw
    );
        logic signed [RS_W-1:0] v;
        logic signed [RS_W-1:0] one_sh;
        logic signed [RS_W-1:0] max_v;
        logic signed [RS_W-1:0] min_v;
        rs_t                    r;
        v = acc >>> shift;
        if (round_en && (shift != 6'd0) && (int'(shift) < acc_w)) begin
            v = v + $signed({{(RS_W-1){1'b0}}, acc[shift - 6'd1]});
        end
        one_sh  = $signed(RS_W'(1)) <<< (dw - 1);
        max_v   = one_sh - $signed(RS_W'(1));
        min_v   = -one_sh;
        r.sat   = 1'b0;
        r.value = v;
        if (v > max_v) begin
            r.sat   = 1'b1;
            r.value = max_v;
        end else if (v < min_v) begin
            r.sat   = 1'b1;
            r.value = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_array_acc_gen_if.sv
// Beat input and result output bundle of the PE array.
interface pe_array_acc_gen_if #(
    parameter int N_ROW = 16,
    parameter int N_COL = 2,
    parameter int DW    = 16,
    parameter int CW    = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N_ROW*DW-1:0]    data_in;
    logic [N_COL*DW-1:0]    weight_in;
    logic [CW-1:0]          num_beats;
    logic                   keep;
    logic                   round_en;
    logic [5:0]             frac_shift;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_COL*N_ROW*DW-1:0] result_o;
    logic [N_COL*N_ROW-1:0] sat_o;
    logic [CW-1:0]          beat_cnt_o;

    modport master (
        output in_valid, data_in, weight_in, num_beats, keep, round_en,
               frac_shift, out_ready,
        input  in_ready, out_valid, result_o, sat_o, beat_cnt_o
    );

    modport slave (
        input  in_valid, data_in, weight_in, num_beats, keep, round_en,
               frac_shift, out_ready,
        output in_ready, out_valid, result_o, sat_o, beat_cnt_o
    );
endinterface

// File: rtl/pe_mac.sv
// Single processing element: signed multiply feeding one wrapping accumulator.
module pe_mac #(
    parameter int DW    = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_en,
    input  logic                    acc_en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc_reg;

    assign prod  = a * b;
    assign acc_o = acc_reg;

    // clr_en only matters on an accumulating cycle: it starts a fresh sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (acc_en) begin
            acc_reg <= (clr_en ? '0 : acc_reg) + ACC_W'(prod);
        end
    end
endmodule

// File: rtl/pe_array_acc_gen.sv
// N_ROW x N_COL outer-product MAC array with grouped accumulation,
// round/saturate to DW and a held result matrix on a valid/ready output.
module pe_array_acc_gen
    import pe_array_pkg::*;
#(
    parameter int N_ROW     = 16,
    parameter int N_COL     = 2,
    parameter int DW        = DW_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_BEATS = 16,
    parameter int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    pe_array_acc_gen_if.slave  bus
);
    state_t                     state_reg;
    logic                       in_ready_reg;
    logic                       out_valid_reg;
    logic [CW-1:0]              beat_cnt_reg;
    logic [CW-1:0]              target_reg;
    logic                       round_en_reg;
    logic [5:0]                 frac_shift_reg;
    logic [N_COL*N_ROW*DW-1:0]  result_reg;
    logic [N_COL*N_ROW-1:0]     sat_reg;

    logic [N_COL*N_ROW*DW-1:0]  res_next;
    logic [N_COL*N_ROW-1:0]     sat_next;
    logic [CW-1:0]              nb_clamped;
    logic [CW-1:0]              beat_cnt_next;
    logic                       acc_en;
    logic                       clr_en;

    // in_ready_reg is high exactly in IDLE/ACCUM, so it doubles as the accept gate.
    assign acc_en        = bus.in_valid && in_ready_reg;
    assign clr_en        = (state_reg == IDLE) && !bus.keep;
    assign beat_cnt_next = beat_cnt_reg + CW'(1);

    always_comb begin
        nb_clamped = bus.num_beats;
        if (bus.num_beats == '0) begin
            nb_clamped = CW'(1);
        end else if (bus.num_beats > CW'(MAX_BEATS)) begin
            nb_clamped = CW'(MAX_BEATS);
        end
    end

    genvar gj, gi;
    generate
        for (gj = 0; gj < N_COL; gj++) begin : g_col
            for (gi = 0; gi < N_ROW; gi++) begin : g_row
                logic signed [ACC_W-1:0] acc_w;
                rs_t                     rs;

                pe_mac #(
                    .DW   (DW),
                    .ACC_W(ACC_W)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .clr_en(clr_en),
                    .acc_en(acc_en),
                    .a     (bus.data_in[gi*DW +: DW]),
                    .b     (bus.weight_in[gj*DW +: DW]),
                    .acc_o (acc_w)
                );

                assign rs = round_sat(RS_W'(acc_w), frac_shift_reg, round_en_reg, ACC_W, DW);
                assign res_next[(gj*N_ROW+gi)*DW +: DW] = DW'(rs.value);
                assign sat_next[gj*N_ROW+gi]            = rs.sat;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            beat_cnt_reg   <= '0;
            target_reg     <= '0;
            round_en_reg   <= 1'b0;
            frac_shift_reg <= '0;
            result_reg     <= '0;
            sat_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        target_reg     <= nb_clamped;
                        round_en_reg   <= bus.round_en;
                        frac_shift_reg <= bus.frac_shift;
                        beat_cnt_reg   <= CW'(1);
                        if (nb_clamped == CW'(1)) begin
                            state_reg    <= ROUND;
                            in_ready_reg <= 1'b0;
                        end else begin
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        beat_cnt_reg <= beat_cnt_next;
                        if (beat_cnt_next == target_reg) begin
                            state_reg    <= ROUND;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                ROUND: begin
                    result_reg    <= res_next;
                    sat_reg       <= sat_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    // Accumulators are left alone so a keep=1 group can extend them.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        beat_cnt_reg  <= '0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.result_o   = result_reg;
    assign bus.sat_o      = sat_reg;
    assign bus.beat_cnt_o = beat_cnt_reg;
endmodule

// File: tb/tb_pe_array_acc_gen.sv
// Directed bench for pe_array_acc_gen: one task per feature, hand-computed expectations.
module tb_pe_array_acc_gen;
    localparam int N_ROW = 16;
    localparam int N_COL = 2;
    localparam int DW    = 16;
    localparam int CW    = 5;
    localparam int RW    = N_COL*N_ROW*DW;
    localparam int SW    = N_COL*N_ROW;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pe_array_acc_gen_if #(.N_ROW(N_ROW), .N_COL(N_COL), .DW(DW), .CW(CW)) bus ();

    pe_array_acc_gen #(
        .N_ROW    (N_ROW),
        .N_COL    (N_COL),
        .DW       (DW),
        .ACC_W    (40),
        .MAX_BEATS(16),
        .CW       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int nb, input bit kp, input bit re, input int fs);
        bus.num_beats  = CW'(nb);
        bus.keep       = kp;
        bus.round_en   = re;
        bus.frac_shift = 6'(fs);
    endtask

    task automatic set_x_const(input int v);
        for (int i = 0; i < N_ROW; i++) bus.data_in[i*DW +: DW] = DW'(v);
    endtask

    task automatic set_x_index();
        for (int i = 0; i < N_ROW; i++) bus.data_in[i*DW +: DW] = DW'(i);
    endtask

    task automatic set_w(input int w0, input int w1);
        bus.weight_in[0 +: DW]  = DW'(w0);
        bus.weight_in[DW +: DW] = DW'(w1);
    endtask

    task automatic send_beat();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [RW-1:0] const_mat(input int c0, input int c1);
        logic [RW-1:0] m;
        for (int i = 0; i < N_ROW; i++) begin
            m[i*DW +: DW]         = DW'(c0);
            m[(N_ROW+i)*DW +: DW] = DW'(c1);
        end
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.beat_cnt_o !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b beat_cnt=%0d expected 1 0 0",
                     bus.in_ready, bus.out_valid, bus.beat_cnt_o);
        end
        tests++;
        if (bus.result_o !== '0 || bus.sat_o !== '0) begin
            fails++;
            $display("FAIL reset_data: result=%h sat=%h expected zero", bus.result_o, bus.sat_o);
        end
        rst = 1'b0;
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        set_cfg(1, 0, 0, 0);
        set_x_const(3);
        set_w(2, -1);
        send_beat();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.beat_cnt_o !== CW'(1)) begin
            fails++;
            $display("FAIL single_round_state: out_valid=%b in_ready=%b beat_cnt=%0d expected 0 0 1",
                     bus.out_valid, bus.in_ready, bus.beat_cnt_o);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_latency: out_valid=%b expected 1", bus.out_valid);
        end
        tests++;
        if (bus.result_o !== const_mat(6, -3) || bus.sat_o !== '0) begin
            fails++;
            $display("FAIL single_result: got %h sat %h expected %h sat 0",
                     bus.result_o, bus.sat_o, const_mat(6, -3));
        end
        drain();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.beat_cnt_o !== '0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_release: out_valid=%b beat_cnt=%0d in_ready=%b expected 0 0 1",
                     bus.out_valid, bus.beat_cnt_o, bus.in_ready);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_multi();
        logic [RW-1:0] exp_res;
        set_cfg(4, 0, 0, 0);
        set_x_index();
        set_w(1, 2);
        for (int k = 1; k <= 4; k++) begin
            send_beat();
            // cfg changes after the first beat must be ignored
            if (k == 1) set_cfg(1, 1, 1, 3);
            tests++;
            if (bus.beat_cnt_o !== CW'(k)) begin
                fails++;
                $display("FAIL multi_beat_cnt: got %0d expected %0d", bus.beat_cnt_o, k);
            end
            if (k == 2) begin
                tick();
                tests++;
                if (bus.beat_cnt_o !== CW'(2) || bus.in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL multi_stall: beat_cnt=%0d in_ready=%b expected 2 1",
                             bus.beat_cnt_o, bus.in_ready);
                end
            end
        end
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL multi_round: in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
        end
        tick();
        for (int i = 0; i < N_ROW; i++) begin
            exp_res[i*DW +: DW]         = DW'(4*i);
            exp_res[(N_ROW+i)*DW +: DW] = DW'(8*i);
        end
        tests++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result_o !== exp_res) begin
            fails++;
            $display("FAIL multi_result: valid=%b ready=%b got %h expected %h",
                     bus.out_valid, bus.in_ready, bus.result_o, exp_res);
        end
        drain();
        $display("[TB] test_multi done");
    endtask

    task automatic test_keep();
        int kp_tab[3]  = '{0, 1, 0};
        int nb_tab[3]  = '{2, 1, 1};
        int exp_tab[3] = '{2, 3, 1};
        set_x_const(1);
        set_w(1, 1);
        for (int g = 0; g < 3; g++) begin
            set_cfg(nb_tab[g], kp_tab[g] != 0, 0, 0);
            for (int b = 0; b < nb_tab[g]; b++) send_beat();
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.result_o !== const_mat(exp_tab[g], exp_tab[g])) begin
                fails++;
                $display("FAIL keep_group%0d: valid=%b got %h expected %0d everywhere",
                         g, bus.out_valid, bus.result_o, exp_tab[g]);
            end
            drain();
        end
        $display("[TB] test_keep done");
    endtask

    task automatic test_round();
        int x_tab[7]   = '{3, 3, -3, -3, -3, 3, 3};
        int re_tab[7]  = '{1, 0, 1, 0, 1, 1, 1};
        int fs_tab[7]  = '{1, 1, 1, 1, 45, 45, 0};
        int exp_tab[7] = '{2, 1, -1, -2, -1, 0, 3};
        set_w(1, 1);
        for (int c = 0; c < 7; c++) begin
            set_cfg(1, 0, re_tab[c] != 0, fs_tab[c]);
            set_x_const(x_tab[c]);
            send_beat();
            tick();
            tests++;
            if (bus.result_o !== const_mat(exp_tab[c], exp_tab[c]) || bus.sat_o !== '0) begin
                fails++;
                $display("FAIL round_case%0d: got %h sat %h expected %0d sat 0",
                         c, bus.result_o, bus.sat_o, exp_tab[c]);
            end
            drain();
        end
        $display("[TB] test_round done");
    endtask

    task automatic test_sat();
        int x_tab[3]   = '{32767, -32768, 32767};
        int w_tab[3]   = '{32767, 32767, 1};
        int exp_tab[3] = '{32767, -32768, 32767};
        bit s_tab[3]   = '{1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 3; c++) begin
            set_cfg(1, 0, 0, 0);
            set_x_const(x_tab[c]);
            set_w(w_tab[c], w_tab[c]);
            send_beat();
            tick();
            tests++;
            if (bus.result_o !== const_mat(exp_tab[c], exp_tab[c]) || bus.sat_o !== {SW{s_tab[c]}}) begin
                fails++;
                $display("FAIL sat_case%0d: got %h sat %h expected %0d sat %b",
                         c, bus.result_o, bus.sat_o, exp_tab[c], s_tab[c]);
            end
            drain();
        end
        $display("[TB] test_sat done");
    endtask

    task automatic test_clamp();
        set_x_const(1);
        set_w(1, 1);
        set_cfg(0, 0, 0, 0);
        send_beat();
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL clamp_zero_ready: in_ready=%b expected 0", bus.in_ready);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.result_o !== const_mat(1, 1)) begin
            fails++;
            $display("FAIL clamp_zero_result: valid=%b got %h expected 1", bus.out_valid, bus.result_o);
        end
        drain();
        set_cfg(20, 0, 0, 0);
        for (int b = 0; b < 15; b++) send_beat();
        tests++;
        if (bus.in_ready !== 1'b1 || bus.beat_cnt_o !== CW'(15)) begin
            fails++;
            $display("FAIL clamp_max_mid: in_ready=%b beat_cnt=%0d expected 1 15", bus.in_ready, bus.beat_cnt_o);
        end
        send_beat();
        tests++;
        if (bus.in_ready !== 1'b0 || bus.beat_cnt_o !== CW'(16)) begin
            fails++;
            $display("FAIL clamp_max_end: in_ready=%b beat_cnt=%0d expected 0 16", bus.in_ready, bus.beat_cnt_o);
        end
        tick();
        tests++;
        if (bus.result_o !== const_mat(16, 16)) begin
            fails++;
            $display("FAIL clamp_max_result: got %h expected 16", bus.result_o);
        end
        drain();
        $display("[TB] test_clamp done");
    endtask

    task automatic test_backpressure();
        set_cfg(1, 0, 0, 0);
        set_x_const(5);
        set_w(1, -1);
        send_beat();
        tick();
        // new beats offered while holding must be refused
        set_x_const(7);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.beat_cnt_o !== CW'(1) ||
                bus.result_o !== const_mat(5, -5)) begin
                fails++;
                $display("FAIL backpressure_cycle%0d: valid=%b ready=%b cnt=%0d got %h expected %h",
                         c, bus.out_valid, bus.in_ready, bus.beat_cnt_o, bus.result_o, const_mat(5, -5));
            end
        end
        bus.in_valid = 1'b0;
        drain();
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_reset_mid();
        set_cfg(4, 0, 0, 0);
        set_x_const(1);
        set_w(1, 1);
        send_beat();
        send_beat();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.beat_cnt_o !== '0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ctrl: valid=%b cnt=%0d ready=%b expected 0 0 1",
                     bus.out_valid, bus.beat_cnt_o, bus.in_ready);
        end
        set_cfg(1, 1, 0, 0);
        send_beat();
        tick();
        tests++;
        if (bus.result_o !== const_mat(1, 1)) begin
            fails++;
            $display("FAIL reset_mid_keep: got %h expected 1 everywhere", bus.result_o);
        end
        drain();
        set_cfg(1, 0, 0, 0);
        set_x_const(2);
        send_beat();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.result_o !== '0) begin
            fails++;
            $display("FAIL reset_hold: valid=%b got %h expected 0 and zero", bus.out_valid, bus.result_o);
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        bus.weight_in = '0;
        set_cfg(1, 0, 0, 0);
        test_reset();
        test_single();
        test_multi();
        test_keep();
        test_round();
        test_sat();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pe_array_acc_gen.md
Name: pe_array_acc_gen

Overview:
Parametrised successor of the fixed 16x2 PE array. It is an outer-product MAC array of N_ROW x N_COL processing elements. Each accepted beat multiplies an N_ROW input vector by an N_COL weight vector and accumulates the result over a programmable number of beats. It then rounds and saturates every accumulator to DW bits and presents the result matrix through a valid/ready handshake to the downstream writeback/buffer stage.

Parameters:
N_ROW, 16, input vector length (elements per beat)
N_COL, 2, weight vector length (output columns)
DW, 16, signed data/weight/result width
ACC_W, 40, signed accumulator width (>= 2*DW + clog2(MAX_BEATS))
MAX_BEATS, 16, max beats per accumulation group
CW, $clog2(MAX_BEATS+1), beat counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  array can accept beat
data_in  in  N_ROW*DW  input vector, element i at [i*DW +: DW], signed
weight_in  in  N_COL*DW  weight vector, element j at [j*DW +: DW], signed
num_beats  in  CW  beats in group; sampled on first beat of a group
keep  in  1  sampled on first beat; 1 = do not clear accumulators at group start
round_en  in  1  1 = round-half-up, 0 = truncate; sampled with num_beats
frac_shift  in  6  arithmetic right shift before saturation; sampled with num_beats
out_valid  out  1  result matrix valid
out_ready  in  1  downstream accepts result
result_o  out  N_COL*N_ROW*DW  result[j][i] at [(j*N_ROW+i)*DW +: DW]
sat_o  out  N_COL*N_ROW  per-element saturation flag, same indexing
beat_cnt_o  out  CW  beats accumulated in current group

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. It overrides all other inputs.
- Reset values: state=IDLE, all accumulators=0, in_ready=1, out_valid=0, result_o=0, sat_o=0, beat_cnt_o=0.
- FSM states: IDLE, ACCUM, ROUND, HOLD.
- IDLE: in_ready=1. On in_valid:
  - latch cfg (num_beats, keep, round_en, frac_shift); num_beats=0 or >MAX_BEATS is clamped to 1 / MAX_BEATS.
  - acc[j][i] <= (keep ? acc[j][i] : 0) + data_in[i]*weight_in[j]; beat_cnt_o <= 1.
  - Go to ROUND if latched count==1, else ACCUM.
- ACCUM: in_ready=1. Each in_valid cycle: acc += product, beat_cnt_o++. No in_valid = stall, state held. When beat_cnt_o reaches latched count (on that beat) -> ROUND.
- ROUND: in_ready=0, one cycle. Per element:
  - v = acc >>> frac_shift.
  - If round_en and frac_shift>0, add bit acc[frac_shift-1].
  - Saturate to [-2^(DW-1), 2^(DW-1)-1]; sat flag = clipped.
  - Register into result_o/sat_o; out_valid <= 1; -> HOLD.
- HOLD: in_ready=0. result_o stable while out_valid && !out_ready. On out_ready: out_valid <= 0, beat_cnt_o <= 0, -> IDLE. Accumulators are retained for a possible keep=1 next group.
- Latency: last accepted beat at cycle t -> out_valid at t+2. Minimum group period = count+2 cycles plus backpressure.
- Arithmetic: products are DW x DW signed -> 2*DW, sign-extended to ACC_W. Accumulator wraps silently on overflow (ACC_W sizing makes this unreachable within MAX_BEATS).
- frac_shift >= ACC_W yields 0 or -1 (sign fill); rounding add applies only when frac_shift < ACC_W.
- Input changes on non-first beats of cfg fields are ignored.
- Simultaneous events: rst mid-group or in HOLD discards all state, including accumulators and pending result. out_ready in IDLE/ACCUM has no effect.

Decomposition:
- Package pe_array_pkg: state enum (IDLE/ACCUM/ROUND/HOLD), a round_sat function (acc, shift, round_en) returning {sat, value}, and defaults for DW/ACC_W.
- Sub-module pe_mac: one PE holding a single accumulator with clear/accumulate enables. Instantiated N_ROW x N_COL by generate. FSM, counter and rounding stay in the top.

Test Plan:
1. Reset then single beat, num_beats=1, frac_shift=0, data all 3, weights {2,-1} -> out_valid at cycle +2; result col0=6, col1=-3; sat=0.
2. num_beats=4, x[i]=i, w={1,2}, keep=0 -> result[0][i]=4i, [1][i]=8i; beat_cnt_o steps 1..4; in_ready low during ROUND/HOLD.
3. Two groups: first num_beats=2 x=1,w=1; second keep=1 num_beats=1 same data -> second result=3. Repeat with keep=0 -> 1.
4. Rounding: single beat x=3,w=1, frac_shift=1. round_en=1 -> 2; round_en=0 -> 1. x=-3: round_en=1 -> -1; truncate -> -2.
5. Saturation: x=32767, w=32767, frac_shift=0 -> result 32767, sat=1. x=-32768, w=32767 -> -32768, sat=1.
6. Backpressure and reset: out_ready held low 5 cycles -> result stable, in_ready=0. rst asserted in ACCUM after 2 of 4 beats -> next cycle out_valid=0, beat_cnt_o=0, IDLE; following group with keep=1 starts from 0.
